mpu_i2c_target: RTL
===================

Name: mpu_i2c_target

Overview:
- I2C target (responder) that emulates the sensor's register interface for the accelerometer read path.
- Used as the bench/loopback model for the I2C master and controller, and as an on-board sensor stand-in.
- Oversamples SCL/SDA on the system clock, decodes START/STOP/address/data, and serves a small register map.
- Drives SDA open-drain only: low or released, never high.

Parameters:
- DEV_ADDR, 7'h68, 7-bit target address matched after START.
- WHO_AM_I_VAL, 8'h68, value returned from register 0x75.
- PWR_RESET, 8'h40, reset value of register 0x6B.

Ports:
- clock  input  1  system clock; must be at least 16x SCL.
- reset  input  1  asynchronous, active-high reset.
- scl  input  1  I2C clock; the target never stretches it.
- sda  inout  1  I2C data; driven 1'b0 when the output enable is set, otherwise 'z.
- sample_x  input  16  live X sample, signed, hi byte at 0x3B.
- sample_y  input  16  live Y sample, hi byte at 0x3D.
- sample_z  input  16  live Z sample, hi byte at 0x3F.
- pwr_mgmt  output  8  contents of register 0x6B.
- busy  output  1  high from address match until STOP or NACK-terminated read.
- rd_done  output  1  one-cycle pulse when the master NACKs the last read byte.

Behaviour:
- Input conditioning:
  - scl and sda pass through 2-flop synchronizers; previous values are registered for edge detection.
  - All protocol decisions use the synchronized signals.
- Bus conditions:
  - START: sda falls while scl is high.
  - STOP: sda rises while scl is high.
  - START and STOP are recognised in every state and take priority over bit handling.
  - A repeated START goes to ADDR without clearing the register pointer.
- Bit timing:
  - Bits are sampled on the synchronized scl rising edge, MSB first.
  - SDA output changes only on the synchronized scl falling edge.
  - A 3-bit counter counts bits 7..0.
- States:
  - IDLE: sda released, busy=0. On START go to ADDR.
  - ADDR: shift 8 bits. If addr[7:1]==DEV_ADDR go to ADDR_ACK and set busy; otherwise go to IGNORE.
  - ADDR_ACK: drive sda low for the 9th bit.
    - R/W=0: go to WR_BYTE.
    - R/W=1: snapshot sample_x/y/z into a 48-bit shadow (so multi-byte reads are coherent), then go to RD_BYTE.
  - WR_BYTE: shift 8 bits, then ACK in WR_ACK.
    - The first byte after an address sets the pointer.
    - Each later byte writes the register at the pointer (only 0x6B is writable; others are ACKed and discarded), then the pointer increments.
  - RD_BYTE: drive sda low for each 0 bit of the byte at the pointer, release it for each 1 bit. Go to RD_ACK.
  - RD_ACK: release sda and sample the master bit.
    - ACK (0): pointer increments; go to RD_BYTE.
    - NACK (1): pulse rd_done, clear busy, go to IGNORE.
  - IGNORE: sda released until START or STOP.
- Register map:
  - 0x3B-0x40 read from the shadow: X hi, X lo, Y hi, Y lo, Z hi, Z lo.
  - 0x6B reads pwr_mgmt.
  - 0x75 reads WHO_AM_I_VAL.
  - All other addresses read 8'h00.
  - The pointer is 8 bits and wraps 0xFF→0x00.
- STOP in any state:
  - Releases sda, clears busy, goes to IDLE.
  - A partially shifted byte is discarded and no register write occurs.
- Reset values (reset is asynchronous, mid-transaction included):
  - state=IDLE, sda released, busy=0, rd_done=0, pointer=0x00, pwr_mgmt=PWR_RESET, shadow=0.
- Latency:
  - sda follows a scl falling edge within 3 clocks (sync + register).
  - pwr_mgmt updates 1 clock after the WR_ACK bit is entered.

Optional Feature:
- I2C_GLITCH_FILTER_EN defined:
  - After the synchronizers, scl and sda each pass through a 3-sample majority filter.
  - Single-clock glitches are rejected.
  - Adds 2 clocks of latency; the clock requirement rises to 20x SCL.
- Not defined: synchronized signals are used directly.

Test Plan:
- Write 0x68+W, 0x3B, repeated START, 0x68+R, read 6 bytes with sample_x=16'h1234, y=16'hABCD, z=16'h8001, NACK on the last byte -> bytes 12,34,AB,CD,80,01; rd_done pulses once; busy drops.
- Change sample_x to 16'h5678 mid-read after byte 0 -> byte 1 still 34, because the snapshot is coherent.
- Address 0x50+W -> 9th bit NACK (sda released); state goes to IGNORE; pwr_mgmt unchanged at 0x40.
- Write 0x68+W, 0x6B, 0x01, STOP -> pwr_mgmt=0x01; read of 0x75 returns 0x68; read of 0x10 returns 0x00.
- STOP after 4 bits of the data byte to 0x6B -> pwr_mgmt unchanged; state IDLE; sda released.
- Assert reset mid RD_BYTE while sda is driven low -> sda releases immediately, pointer=0x00, busy=0; the next transaction is ACKed normally.

Source files
------------

// File: rtl/mpu_i2c_target.sv
// I2C target serving the accelerometer register map (samples, PWR_MGMT_1, WHO_AM_I).
// Define I2C_GLITCH_FILTER_EN to add a 3-sample majority filter after the synchronizers.
module mpu_i2c_target #(
    parameter logic [6:0] DEV_ADDR     = 7'h68,
    parameter logic [7:0] WHO_AM_I_VAL = 8'h68,
    parameter logic [7:0] PWR_RESET    = 8'h40
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        scl,
    inout  wire         sda,
    input  logic [15:0] sample_x,
    input  logic [15:0] sample_y,
    input  logic [15:0] sample_z,
    output logic [7:0]  pwr_mgmt,
    output logic        busy,
    output logic        rd_done
);

    typedef enum logic [2:0] {
        StIdle, StAddr, StAddrAck, StWrByte, StWrAck, StRdByte, StRdAck, StIgnore
    } state_e;

    logic [1:0]  scl_sync_q, sda_sync_q;
    logic        scl_s, sda_s;
    logic        scl_prev_q, sda_prev_q;
    logic        scl_rise, scl_fall, start_det, stop_det;

    state_e      state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        rw_q, rw_d;
    logic        first_q, first_d;
    logic [7:0]  ptr_q, ptr_d;
    logic [7:0]  pwr_q, pwr_d;
    logic [47:0] shadow_q, shadow_d;
    logic        oe_q, oe_d;
    logic        busy_q, busy_d;
    logic        rd_done_q, rd_done_d;
    logic [7:0]  rx_byte;
    logic [7:0]  rd_data;

    // Synchronizers reset to the idle-bus level so reset release never looks like START.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl};
            sda_sync_q <= {sda_sync_q[0], sda};
        end
    end

`ifdef I2C_GLITCH_FILTER_EN
    logic [2:0] scl_hist_q, sda_hist_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            scl_hist_q <= 3'b111;
            sda_hist_q <= 3'b111;
        end else begin
            scl_hist_q <= {scl_hist_q[1:0], scl_sync_q[1]};
            sda_hist_q <= {sda_hist_q[1:0], sda_sync_q[1]};
        end
    end

    assign scl_s = (scl_hist_q[0] & scl_hist_q[1]) | (scl_hist_q[1] & scl_hist_q[2]) |
                   (scl_hist_q[0] & scl_hist_q[2]);
    assign sda_s = (sda_hist_q[0] & sda_hist_q[1]) | (sda_hist_q[1] & sda_hist_q[2]) |
                   (sda_hist_q[0] & sda_hist_q[2]);
`else
    assign scl_s = scl_sync_q[1];
    assign sda_s = sda_sync_q[1];
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end

    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
    assign rx_byte   = {shift_q[6:0], sda_s};

    always_comb begin
        rd_data = 8'h00;
        case (ptr_q)
            8'h3B:   rd_data = shadow_q[47:40];
            8'h3C:   rd_data = shadow_q[39:32];
            8'h3D:   rd_data = shadow_q[31:24];
            8'h3E:   rd_data = shadow_q[23:16];
            8'h3F:   rd_data = shadow_q[15:8];
            8'h40:   rd_data = shadow_q[7:0];
            8'h6B:   rd_data = pwr_q;
            8'h75:   rd_data = WHO_AM_I_VAL;
            default: rd_data = 8'h00;
        endcase
    end

    // Ack/data states span rise-to-rise: the fall inside drives sda, the closing rise moves on.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        rw_d      = rw_q;
        first_d   = first_q;
        ptr_d     = ptr_q;
        pwr_d     = pwr_q;
        shadow_d  = shadow_q;
        oe_d      = oe_q;
        busy_d    = busy_q;
        rd_done_d = 1'b0;

        if (start_det) begin
            state_d   = StAddr;
            bit_cnt_d = 3'd7;
            oe_d      = 1'b0;
        end else if (stop_det) begin
            state_d = StIdle;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: oe_d = 1'b0;
                StAddr: begin
                    if (scl_rise) begin
                        shift_d = rx_byte;
                        if (bit_cnt_q == 3'd0) begin
                            if (rx_byte[7:1] == DEV_ADDR) begin
                                state_d = StAddrAck;
                                busy_d  = 1'b1;
                                rw_d    = rx_byte[0];
                            end else begin
                                state_d = StIgnore;
                                busy_d  = 1'b0;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q - 3'd1;
                        end
                    end
                end
                StAddrAck: begin
                    if (scl_fall) oe_d = 1'b1;
                    if (scl_rise) begin
                        bit_cnt_d = 3'd7;
                        if (rw_q) begin
                            shadow_d = {sample_x, sample_y, sample_z};
                            state_d  = StRdByte;
                        end else begin
                            first_d = 1'b1;
                            state_d = StWrByte;
                        end
                    end
                end
                StWrByte: begin
                    if (scl_fall) oe_d = 1'b0;
                    if (scl_rise) begin
                        shift_d = rx_byte;
                        if (bit_cnt_q == 3'd0) begin
                            state_d = StWrAck;
                            if (first_q) begin
                                ptr_d   = rx_byte;
                                first_d = 1'b0;
                            end else begin
                                if (ptr_q == 8'h6B) pwr_d = rx_byte;
                                ptr_d = ptr_q + 8'd1;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q - 3'd1;
                        end
                    end
                end
                StWrAck: begin
                    if (scl_fall) oe_d = 1'b1;
                    if (scl_rise) begin
                        bit_cnt_d = 3'd7;
                        state_d   = StWrByte;
                    end
                end
                StRdByte: begin
                    if (scl_fall) oe_d = ~rd_data[bit_cnt_q];
                    if (scl_rise) begin
                        if (bit_cnt_q == 3'd0) state_d = StRdAck;
                        else bit_cnt_d = bit_cnt_q - 3'd1;
                    end
                end
                StRdAck: begin
                    if (scl_fall) oe_d = 1'b0;
                    if (scl_rise) begin
                        if (!sda_s) begin
                            ptr_d     = ptr_q + 8'd1;
                            bit_cnt_d = 3'd7;
                            state_d   = StRdByte;
                        end else begin
                            rd_done_d = 1'b1;
                            busy_d    = 1'b0;
                            state_d   = StIgnore;
                        end
                    end
                end
                StIgnore: oe_d = 1'b0;
                default: begin
                    state_d = StIdle;
                    oe_d    = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            bit_cnt_q <= 3'd7;
            shift_q   <= 8'h00;
            rw_q      <= 1'b0;
            first_q   <= 1'b0;
            ptr_q     <= 8'h00;
            pwr_q     <= PWR_RESET;
            shadow_q  <= 48'h0;
            oe_q      <= 1'b0;
            busy_q    <= 1'b0;
            rd_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            rw_q      <= rw_d;
            first_q   <= first_d;
            ptr_q     <= ptr_d;
            pwr_q     <= pwr_d;
            shadow_q  <= shadow_d;
            oe_q      <= oe_d;
            busy_q    <= busy_d;
            rd_done_q <= rd_done_d;
        end
    end

    assign sda      = oe_q ? 1'b0 : 1'bz;
    assign pwr_mgmt = pwr_q;
    assign busy     = busy_q;
    assign rd_done  = rd_done_q;

endmodule
